// File: rtl/fir_capture_buffer_pkg.sv
// fir_cap_pkg: shared types and default sizes for the FIR capture buffer.
// The FIR benches also use it.
//   cap_state_t : capture FSM state encoding
//   WD_DEF      : default sample width (two's complement)
//   DEPTH_DEF   : default capture window length (power of 2, >= 4)
package fir_cap_pkg;

  localparam int WD_DEF    = 24;
  localparam int DEPTH_DEF = 1024;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    READOUT = 2'd3
  } cap_state_t;

endpackage

// File: rtl/fir_capture_buffer_if.sv
// fir_capture_buffer_if: valid/ready readout stream from the capture buffer.
// The host is a logger, a UART bridge or a testbench.
//   rd_data  : readout sample
//   rd_valid : rd_data valid
//   rd_ready : sink accepts rd_data
//   rd_last  : qualifies the final sample of the window
// Modports: master = capture buffer side, slave = host side.
interface fir_capture_buffer_if
  import fir_cap_pkg::*;
#(
  parameter int WD = WD_DEF
);
  logic [WD-1:0] rd_data;
  logic          rd_valid;
  logic          rd_ready;
  logic          rd_last;

  modport master (output rd_data, output rd_valid, output rd_last, input rd_ready);
  modport slave  (input rd_data, input rd_valid, input rd_last, output rd_ready);
endinterface

// File: rtl/fir_capture_buffer_ram.sv
// cap_ram: simple dual-port sample store, WD x DEPTH.
// It has one write port and one synchronous read port, and no reset.
//   clk       : system clock
//   i_wr_en   : write strobe
//   i_wr_addr : write address
//   i_wr_data : write sample
//   i_rd_addr : read address, data appears on o_rd_data one cycle later
//   o_rd_data : registered read sample
module cap_ram
  import fir_cap_pkg::*;
#(
  parameter  int WD    = WD_DEF,
  parameter  int DEPTH = DEPTH_DEF,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 i_wr_en,
  input  logic [AW-1:0]        i_wr_addr,
  input  logic signed [WD-1:0] i_wr_data,
  input  logic [AW-1:0]        i_rd_addr,
  output logic signed [WD-1:0] o_rd_data
);

  logic signed [WD-1:0] r_mem [DEPTH];
  logic signed [WD-1:0] r_q;

  always_ff @(posedge clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
    r_q <= r_mem[i_rd_addr];
  end

  assign o_rd_data = r_q;

endmodule

// File: rtl/fir_capture_buffer.sv
// fir_capture_buffer: records DEPTH filtered samples, either at once or after a signed
// level crossing, then streams the window out over a valid/ready interface.
//   clk, reset     : system clock, synchronous active-high reset
//   sample_in      : FIR output sample (signed), qualified by sample_valid
//   arm            : pulse, starts a capture when idle
//   abort          : pulse, drops the current operation and returns to idle
//   trig_en        : 1 = wait for a level crossing, 0 = capture the next valid sample
//   trig_level     : signed threshold, latched together with arm
//   rd_if (master) : readout stream rd_data/rd_valid/rd_ready/rd_last
//   busy           : capture or readout in progress
//   done           : one-cycle pulse after the final readout transfer
module fir_capture_buffer
  import fir_cap_pkg::*;
#(
  parameter  int WD    = WD_DEF,
  parameter  int DEPTH = DEPTH_DEF,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic signed [WD-1:0] sample_in,
  input  logic                 sample_valid,
  input  logic                 arm,
  input  logic                 abort,
  input  logic                 trig_en,
  input  logic signed [WD-1:0] trig_level,
  fir_capture_buffer_if.master rd_if,
  output logic                 busy,
  output logic                 done
);

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  cap_state_t           r_state, w_state_nxt;
  logic [AW-1:0]        r_wr_ptr, r_rd_ptr;
  logic signed [WD-1:0] r_prev, r_level;
  logic                 r_trig_en, r_rd_valid, r_done;

  logic                 w_hit, w_wr_en, w_xfer;
  logic [AW-1:0]        w_wr_addr, w_rd_addr;
  logic signed [WD-1:0] w_ram_q;

  // Rising crossing: the previous sample is strictly below the level and the new one reaches it.
  function automatic logic level_hit(input logic signed [WD-1:0] prev,
                                     input logic signed [WD-1:0] level,
                                     input logic signed [WD-1:0] smp);
    return (prev < level) && (level <= smp);
  endfunction

  // The read address looks one transfer ahead.
  // Because of that, the synchronous RAM output always holds mem[r_rd_ptr].
  // It holds that sample during stalls too, so no extra data register is needed.
  always_comb begin
    w_state_nxt = r_state;
    w_wr_en     = 1'b0;
    w_wr_addr   = r_wr_ptr;
    w_rd_addr   = r_rd_ptr;
    w_xfer      = 1'b0;
    w_hit       = !r_trig_en || level_hit(r_prev, r_level, sample_in);
    unique case (r_state)
      IDLE: begin
        if (arm) w_state_nxt = ARMED;
      end
      ARMED: begin
        if (sample_valid && w_hit) begin
          w_wr_en     = 1'b1;
          w_wr_addr   = '0;
          w_state_nxt = CAPTURE;
        end
      end
      CAPTURE: begin
        if (sample_valid) begin
          w_wr_en = 1'b1;
          if (r_wr_ptr == LAST) w_state_nxt = READOUT;
        end
      end
      READOUT: begin
        w_xfer = r_rd_valid && rd_if.rd_ready;
        if (w_xfer) begin
          w_rd_addr = r_rd_ptr + AW'(1);
          if (r_rd_ptr == LAST) w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    if (abort) begin
      w_state_nxt = IDLE;
      w_wr_en     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_prev     <= '0;
      r_level    <= '0;
      r_trig_en  <= 1'b0;
      r_rd_valid <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (arm && !abort) begin
            r_trig_en <= trig_en;
            r_level   <= trig_level;
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_prev    <= '0;
          end
        end
        ARMED: begin
          if (sample_valid) begin
            if (w_hit) r_wr_ptr <= AW'(1);
            else       r_prev   <= sample_in;
          end
        end
        CAPTURE: begin
          if (sample_valid) r_wr_ptr <= r_wr_ptr + AW'(1);
        end
        READOUT: begin
          // The first cycle only issues the read of mem[0]; valid rises once it lands.
          if (!r_rd_valid) begin
            r_rd_valid <= 1'b1;
          end else if (w_xfer) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
            if (r_rd_ptr == LAST) begin
              r_rd_valid <= 1'b0;
              r_done     <= 1'b1;
            end
          end
        end
        default: ;
      endcase
      if (abort) begin
        r_rd_valid <= 1'b0;
        r_done     <= 1'b0;
        r_rd_ptr   <= '0;
      end
    end
  end

  cap_ram #(.WD(WD), .DEPTH(DEPTH)) u_ram (
    .clk       (clk),
    .i_wr_en   (w_wr_en),
    .i_wr_addr (w_wr_addr),
    .i_wr_data (sample_in),
    .i_rd_addr (w_rd_addr),
    .o_rd_data (w_ram_q)
  );

  // RAM contents are undefined after reset, so the data bus is forced to zero when not valid.
  assign rd_if.rd_data  = r_rd_valid ? w_ram_q : '0;
  assign rd_if.rd_valid = r_rd_valid;
  assign rd_if.rd_last  = r_rd_valid && (r_rd_ptr == LAST);
  assign busy           = (r_state != IDLE);
  assign done           = r_done;

endmodule

// File: tb/tb_fir_capture_buffer.sv
// Testbench for fir_capture_buffer with DEPTH=8.
// A spec-level capture model pushes the expected samples to a scoreboard queue.
// Readout transfers pop the queue and compare.
module tb_fir_capture_buffer;
  localparam int WD    = 24;
  localparam int DEPTH = 8;

  logic                 clk = 1'b0;
  logic                 reset;
  logic signed [WD-1:0] sample_in;
  logic                 sample_valid, arm, abort, trig_en;
  logic signed [WD-1:0] trig_level;
  logic                 busy, done;

  fir_capture_buffer_if #(.WD(WD)) rd_if ();

  fir_capture_buffer #(.WD(WD), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .arm          (arm),
    .abort        (abort),
    .trig_en      (trig_en),
    .trig_level   (trig_level),
    .rd_if        (rd_if),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Capture model. State codes: 0 idle, 1 armed, 2 capturing, 3 window full.
  logic signed [WD-1:0] sb[$];
  int                   m_state = 0;
  int                   m_cnt   = 0;
  bit                   m_te;
  logic signed [WD-1:0] m_prev, m_lvl;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_arm(input bit te, input logic signed [WD-1:0] lvl);
    arm = 1'b1; trig_en = te; trig_level = lvl;
    if (m_state == 0) begin
      m_state = 1; m_prev = '0; m_te = te; m_lvl = lvl; m_cnt = 0;
    end
    tick();
    arm = 1'b0;
  endtask

  task automatic feed(input logic signed [WD-1:0] v, input bit vld);
    sample_in = v; sample_valid = vld;
    if (vld) begin
      if (m_state == 1) begin
        if (!m_te || (m_prev < m_lvl && m_lvl <= v)) begin
          sb.push_back(v); m_cnt = 1; m_state = 2;
        end else begin
          m_prev = v;
        end
      end else if (m_state == 2) begin
        sb.push_back(v); m_cnt++;
        if (m_cnt == DEPTH) m_state = 3;
      end
    end
    tick();
    sample_valid = 1'b0;
  endtask

  // Drains one window from the DUT.
  // Along the way it checks order, rd_last, stall stability and the done pulse.
  // For junk_n cycles it also drives sample_valid; those samples must be dropped.
  task automatic readout(input bit rand_rdy, input int junk_n, output int first_lat);
    int n, cyc;
    bit stall, seen_done;
    logic [WD-1:0] pd;
    logic signed [WD-1:0] exp_d;
    n = 0; cyc = 0; stall = 1'b0; seen_done = 1'b0; first_lat = -1; pd = '0;
    while (n < DEPTH && cyc < 200) begin
      if (stall) begin
        n_checks++;
        if (rd_if.rd_valid !== 1'b1 || rd_if.rd_data !== pd) begin
          n_fail++;
          $display("FAIL stall_hold: valid=%b data=%0h, required valid=1 data=%0h",
                   rd_if.rd_valid, rd_if.rd_data, pd);
        end
      end
      if (rd_if.rd_valid === 1'b1 && first_lat < 0) first_lat = cyc;
      if (done === 1'b1) seen_done = 1'b1;
      rd_if.rd_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      sample_valid = (cyc < junk_n);
      sample_in = WD'(DEPTH + 1 + cyc);
      stall = (rd_if.rd_valid === 1'b1) && !rd_if.rd_ready;
      pd = rd_if.rd_data;
      if (rd_if.rd_valid === 1'b1 && rd_if.rd_ready) begin
        exp_d = (sb.size() > 0) ? sb.pop_front() : '0;
        n_checks++;
        if (rd_if.rd_data !== exp_d) begin
          n_fail++;
          $display("FAIL rd_data[%0d]: got %0d, required %0d", n, $signed(rd_if.rd_data), exp_d);
        end
        n_checks++;
        if (rd_if.rd_last !== (n == DEPTH - 1)) begin
          n_fail++;
          $display("FAIL rd_last[%0d]: got %b, required %b", n, rd_if.rd_last, (n == DEPTH - 1));
        end
        n++;
      end
      tick();
      cyc++;
    end
    rd_if.rd_ready = 1'b0; sample_valid = 1'b0;
    m_state = 0;
    n_checks++;
    if (n != DEPTH) begin
      n_fail++;
      $display("FAIL readout_count: got %0d transfers, required %0d", n, DEPTH);
    end
    n_checks++;
    if (done !== 1'b1 || rd_if.rd_valid !== 1'b0 || busy !== 1'b0 || seen_done) begin
      n_fail++;
      $display("FAIL done_end: done=%b valid=%b busy=%b early_done=%b, required 1 0 0 0",
               done, rd_if.rd_valid, busy, seen_done);
    end
    tick();
    n_checks++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("FAIL done_pulse: got %b a cycle later, required 0", done);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; sample_in = '0; sample_valid = 1'b0; arm = 1'b0; abort = 1'b0;
    trig_en = 1'b0; trig_level = '0; rd_if.rd_ready = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    n_checks++;
    if (rd_if.rd_valid !== 1'b0 || rd_if.rd_last !== 1'b0) begin
      n_fail++; $display("FAIL reset_valid: valid=%b last=%b, required 0 0", rd_if.rd_valid, rd_if.rd_last);
    end
    n_checks++;
    if (rd_if.rd_data !== '0) begin
      n_fail++; $display("FAIL reset_data: got %0h, required 0", rd_if.rd_data);
    end
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL reset_status: busy=%b done=%b, required 0 0", busy, done);
    end
  endtask

  task automatic test_immediate();
    int lat;
    do_arm(1'b0, '0);
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++; $display("FAIL arm_busy: got %b, required 1", busy);
    end
    for (int i = 1; i <= DEPTH; i++) feed(WD'(i), 1'b1);
    readout(1'b0, 2, lat);
    n_checks++;
    if (lat < 0 || lat > 2) begin
      n_fail++; $display("FAIL first_valid_latency: got %0d, required 0..2", lat);
    end
  endtask

  task automatic test_trigger();
    int lat;
    int vals[10] = '{-3, -1, 2, 5, 7, 9, 11, 13, 15, 17};
    do_arm(1'b1, '0);
    for (int i = 0; i < 10; i++) feed(WD'(vals[i]), 1'b1);
    n_checks++;
    if (sb.size() != DEPTH || sb[0] !== WD'(2)) begin
      n_fail++; $display("FAIL trig_model: %0d queued, required %0d", sb.size(), DEPTH);
    end
    readout(1'b0, 0, lat);
  endtask

  task automatic test_gaps();
    int lat;
    do_arm(1'b0, '0);
    for (int i = 0; i < 100 && m_state != 3; i++) feed(WD'(100 + i), (i % 3) == 0);
    readout(1'b0, 0, lat);
  endtask

  task automatic test_backpressure();
    int lat;
    do_arm(1'b0, '0);
    for (int i = 0; i < DEPTH; i++) begin
      arm = (i == 4);
      feed(WD'($urandom), 1'b1);
    end
    arm = 1'b0;
    readout(1'b1, 0, lat);
  endtask

  task automatic test_abort();
    int lat;
    do_arm(1'b0, '0);
    for (int i = 0; i < 3; i++) feed(WD'(50 + i), 1'b1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    sb.delete(); m_state = 0;
    n_checks++;
    if (busy !== 1'b0 || rd_if.rd_valid !== 1'b0) begin
      n_fail++; $display("FAIL abort_idle: busy=%b valid=%b, required 0 0", busy, rd_if.rd_valid);
    end
    for (int i = 0; i < 4; i++) begin
      sample_valid = 1'b1; sample_in = WD'(77);
      tick();
      n_checks++;
      if (rd_if.rd_valid !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
        n_fail++; $display("FAIL abort_quiet: valid=%b done=%b busy=%b, required 0 0 0",
                           rd_if.rd_valid, done, busy);
      end
    end
    sample_valid = 1'b0;
    do_arm(1'b0, '0);
    for (int i = 0; i < DEPTH; i++) feed(WD'(-20 - i), 1'b1);
    readout(1'b1, 0, lat);
  endtask

  task automatic test_reset_in_readout();
    int n;
    logic signed [WD-1:0] exp_d;
    do_arm(1'b0, '0);
    for (int i = 0; i < DEPTH; i++) feed(WD'(200 + i), 1'b1);
    rd_if.rd_ready = 1'b1;
    n = 0;
    for (int c = 0; c < 20 && n < 4; c++) begin
      if (rd_if.rd_valid === 1'b1) begin
        exp_d = sb.pop_front();
        n_checks++;
        if (rd_if.rd_data !== exp_d) begin
          n_fail++; $display("FAIL pre_reset_data[%0d]: got %0d, required %0d", n, $signed(rd_if.rd_data), exp_d);
        end
        n++;
      end
      tick();
    end
    reset = 1'b1;
    tick();
    reset = 1'b0; rd_if.rd_ready = 1'b0;
    sb.delete(); m_state = 0;
    n_checks++;
    if (rd_if.rd_valid !== 1'b0 || rd_if.rd_data !== '0 || rd_if.rd_last !== 1'b0 ||
        busy !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL reset_in_readout: valid=%b data=%0h last=%b busy=%b done=%b, required all 0",
                         rd_if.rd_valid, rd_if.rd_data, rd_if.rd_last, busy, done);
    end
    arm = 1'b1; abort = 1'b1;
    tick();
    arm = 1'b0; abort = 1'b0;
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if (busy !== 1'b0) begin
        n_fail++; $display("FAIL arm_abort_idle: busy=%b, required 0", busy);
      end
      sample_valid = 1'b1; sample_in = WD'(5);
      tick();
    end
    sample_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_immediate();
    test_trigger();
    test_gaps();
    test_backpressure();
    test_abort();
    test_reset_in_readout();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
